// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// recode operations and the default operand width.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RC_NOP = 2'd0,
        RC_ADD = 2'd1,
        RC_SUB = 2'd2
    } recode_e;

    // Radix-2 Booth recoding of the pair {Q[0], q-1}
    function automatic recode_e booth_recode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return RC_ADD;
            2'b10:   return RC_SUB;
            default: return RC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth step: recode {Q[0],q-1}, add/sub M into A,
// then arithmetic shift of {A,Q,q-1} right by one.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // A carries one guard bit so subtracting the most-negative M cannot overflow
    assign m_ext = {m_i[WIDTH-1], m_i};

    always_comb begin
        sum = a_i;
        case (booth_recode(q_i[0], qm1_i))
            RC_ADD:  sum = a_i + m_ext;
            RC_SUB:  sum = a_i - m_ext;
            default: sum = a_i;
        endcase
    end

    assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-2 Booth multiplier, one step per clock, valid/ready on both sides.
// Optional BOOTH_EARLY_TERM_EN collapses trailing pure-shift steps into one clock.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH:0]     a_s;
    logic [WIDTH-1:0]   q_s;
    logic               qm1_s;
    logic [WIDTH:0]     a_d;
    logic [WIDTH-1:0]   q_d;
    logic               last_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_s),
        .q_o   (q_s),
        .qm1_o (qm1_s)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0]    rem;
    logic [WIDTH-1:0] mask;
    logic [2*WIDTH:0] aq_sh;
    logic             early;

    // After this step, if the remaining multiplier bits and q-1 are uniform,
    // every later recode is NOP and only shifts remain.
    always_comb begin
        rem   = cnt_q - CW'(1);
        mask  = ~({WIDTH{1'b1}} << rem);
        early = (rem != '0) &&
                ((((q_s & mask) == '0) && !qm1_s) ||
                 (((q_s & mask) == mask) && qm1_s));
        aq_sh  = $signed({a_s, q_s}) >>> rem;
        a_d    = early ? aq_sh[2*WIDTH:WIDTH] : a_s;
        q_d    = early ? aq_sh[WIDTH-1:0]     : q_s;
        last_d = early || (rem == '0);
    end
`else
    always_comb begin
        a_d    = a_s;
        q_d    = q_s;
        last_d = (cnt_q == CW'(1));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            a_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        m_q        <= a;
                        q_q        <= b;
                        a_q        <= '0;
                        qm1_q      <= 1'b0;
                        cnt_q      <= CW'(WIDTH);
                        state_q    <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_s;
                    cnt_q <= last_d ? '0 : cnt_q - CW'(1);
                    if (last_d) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        product_q   <= {a_d[WIDTH-1:0], q_d};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
